// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - generic pipeline stage register with two-entry skid buffer, flush, NOP injection and stall counter
module pipe_stage_skid #(
  parameter int              WIDTH     = 32,
  parameter logic [WIDTH-1:0] NOP_VALUE = {WIDTH{1'b0}},
  parameter int              CNT_W     = 16
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             nop_inject,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] STALL_MAX = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic             accept;
  logic             pop;
  logic [WIDTH-1:0] entry;

  // Outputs decode only from flops, so nothing upstream or downstream
  // reaches them combinationally.
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign occupancy = state_q;
  assign stall_cnt = stall_q;

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;
  assign entry  = nop_inject ? NOP_VALUE : in_data;

  // Next-state, storage load and stall counter update.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    stall_d = stall_q;

    // Counter runs independently of flush and saturates instead of wrapping.
    if (out_valid && !out_ready && (stall_q != STALL_MAX)) begin
      stall_d = stall_q + CNT_W'(1);
    end

    if (flush) begin
      // Everything held is killed; out_data keeps its last value.
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            main_d  = entry;
            state_d = ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            main_d = entry;
          end else if (accept) begin
            skid_d  = entry;
            state_d = FULL;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so only a pop can happen; skid drains first.
          if (pop) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  // State and storage registers with asynchronous reset.
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      state_q <= EMPTY;
      main_q  <= NOP_VALUE;
      skid_q  <= NOP_VALUE;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      stall_q <= stall_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - scoreboard bench for pipe_stage_skid
module tb_pipe_stage_skid;

  localparam int          WIDTH = 32;
  localparam int          CNT_W = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] SMAX  = 32'd15;

  logic             Clk;
  logic             Clr;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             nop_inject;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       occupancy;
  logic [CNT_W-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  logic [31:0] sb_q[$];
  logic [31:0] exp_out;
  logic [31:0] exp_stall;

  pipe_stage_skid #(
    .WIDTH    (WIDTH),
    .NOP_VALUE(NOP),
    .CNT_W    (CNT_W)
  ) dut (
    .Clk       (Clk),
    .Clr       (Clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .nop_inject(nop_inject),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    int n;
    n = sb_q.size();
    check({tag, ".occupancy"}, 32'(occupancy), 32'(n));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(n != 0));
    check({tag, ".in_ready"},  32'(in_ready),  32'(n < 2));
    check({tag, ".out_data"},  out_data, exp_out);
    check({tag, ".stall_cnt"}, 32'(stall_cnt), exp_stall);
  endtask

  // One clock cycle: drive inputs, update the model, then check after the edge.
  task automatic step(input string tag, input logic v, input logic [31:0] d,
                      input logic nop, input logic fl, input logic ordy,
                      output logic accepted);
    logic        acc;
    logic        pp;
    logic [31:0] head;
    in_valid   = v;
    in_data    = d;
    nop_inject = nop;
    flush      = fl;
    out_ready  = ordy;
    acc = v && (sb_q.size() < 2);
    pp  = (sb_q.size() != 0) && ordy;
    if ((sb_q.size() != 0) && !ordy && (exp_stall != SMAX)) exp_stall = exp_stall + 1;
    if (pp) begin
      head = sb_q.pop_front();
      check({tag, ".pop_data"}, out_data, head);
    end
    if (fl) sb_q.delete();
    else if (acc) sb_q.push_back(nop ? NOP : d);
    accepted = acc && !fl;
    @(posedge Clk);
    #1;
    if (sb_q.size() != 0) exp_out = sb_q[0];
    check_state(tag);
  endtask

  // Asserts Clr between edges and checks the outputs before the next edge.
  task automatic apply_reset(input string tag);
    #1 Clr = 1'b1;
    in_valid   = 1'b0;
    nop_inject = 1'b0;
    flush      = 1'b0;
    out_ready  = 1'b0;
    sb_q.delete();
    exp_out   = NOP;
    exp_stall = 0;
    #1 check_state(tag);
    @(posedge Clk);
    #1 Clr = 1'b0;
  endtask

  logic acc;
  int   guard;

  initial begin
    Clr        = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    nop_inject = 1'b0;
    flush      = 1'b0;
    out_ready  = 1'b0;
    exp_out    = NOP;
    exp_stall  = 0;

    @(posedge Clk);
    apply_reset("reset");

    // Streaming with downstream always ready.
    step("stream", 1'b1, 32'h11, 1'b0, 1'b0, 1'b1, acc);
    step("stream", 1'b1, 32'h22, 1'b0, 1'b0, 1'b1, acc);
    step("stream", 1'b1, 32'h33, 1'b0, 1'b0, 1'b1, acc);
    step("stream_drain", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, acc);

    // Skid fill, then drain in order while the third payload waits upstream.
    step("skid", 1'b1, 32'hA1, 1'b0, 1'b0, 1'b0, acc);
    step("skid", 1'b1, 32'hA2, 1'b0, 1'b0, 1'b0, acc);
    step("skid_held", 1'b1, 32'hA3, 1'b0, 1'b0, 1'b0, acc);
    check("skid_a3_blocked", 32'(acc), 32'd0);
    guard = 0;
    acc   = 1'b0;
    while (!acc && guard < 10) begin
      step("skid_retry", 1'b1, 32'hA3, 1'b0, 1'b0, 1'b1, acc);
      guard++;
    end
    check("skid_a3_accepted", 32'(acc), 32'd1);
    for (int i = 0; i < 3; i++) step("skid_drain", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, acc);
    check("skid_stall_total", 32'(stall_cnt), 32'd2);

    // NOP injection followed by an unmodified payload.
    step("nop", 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1, acc);
    check("nop_out", out_data, NOP);
    step("nop_next", 1'b1, 32'hCAFE0001, 1'b0, 1'b0, 1'b1, acc);
    check("nop_pass", out_data, 32'hCAFE0001);
    step("nop_ignored", 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, acc);

    // Flush from FULL with a simultaneous offer.
    step("flush_fill", 1'b1, 32'hB1, 1'b0, 1'b0, 1'b0, acc);
    step("flush_fill", 1'b1, 32'hB2, 1'b0, 1'b0, 1'b0, acc);
    step("flush", 1'b1, 32'hB3, 1'b0, 1'b1, 1'b0, acc);
    check("flush_keep_b1", out_data, 32'hB1);
    step("flush_idle", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, acc);

    // Flush with accept and pop together.
    step("flush2_fill", 1'b1, 32'hC1, 1'b0, 1'b0, 1'b1, acc);
    step("flush2", 1'b1, 32'hC2, 1'b0, 1'b1, 1'b1, acc);

    // Counter saturation.
    apply_reset("sat_pre");
    step("sat_fill", 1'b1, 32'h55, 1'b0, 1'b0, 1'b0, acc);
    for (int i = 0; i < 20; i++) step("sat", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, acc);
    check("sat_hold", 32'(stall_cnt), 32'd15);
    apply_reset("sat_clr");

    // Asynchronous reset while FULL.
    step("async_fill", 1'b1, 32'hE1, 1'b0, 1'b0, 1'b0, acc);
    step("async_fill", 1'b1, 32'hE2, 1'b0, 1'b0, 1'b0, acc);
    apply_reset("async_rst");

    // Randomised traffic against the scoreboard.
    for (int i = 0; i < 400; i++) begin
      step("rand", 1'($urandom_range(0, 1)), $urandom(),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 19) == 0),
           1'($urandom_range(0, 1)), acc);
    end
    for (int i = 0; i < 3; i++) step("rand_drain", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, acc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline stage register with a valid/ready handshake, a two-entry skid buffer, synchronous flush, NOP injection and a saturating stall counter. It replaces the fixed-format IF/ID, ID/EX, EX/MEM and MEM/WB registers with one generic stage. Upstream back-pressure is decoupled through registered paths, so no combinational path crosses the stage. Branch flushes and hazard bubbles are applied in-stage rather than by external muxes.

## Interface
- WIDTH, 32, payload width in bits (instruction, control and data fields concatenated by the instantiating stage)
- NOP_VALUE, {WIDTH{1'b0}}, payload stored in place of in_data when a bubble is injected; also the reset value of out_data
- CNT_W, 16, width of the stall counter

Ports:
- Clk  in  1  clock, rising-edge
- Clr  in  1  reset, asynchronous, active-high
- in_valid  in  1  upstream presents a payload
- in_ready  out  1  stage can accept; registered
- in_data  in  WIDTH  upstream payload
- nop_inject  in  1  on an accepted transfer, store NOP_VALUE instead of in_data
- flush  in  1  synchronous kill of all held entries
- out_valid  out  1  out_data holds a valid entry; registered
- out_ready  in  1  downstream consumes when out_valid is high
- out_data  out  WIDTH  head entry; registered
- occupancy  out  2  entries held: 0, 1 or 2
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

## Operation
- accept = in_valid & in_ready; pop = out_valid & out_ready. Both are evaluated at the rising edge.
- Storage:
  - main register drives out_data.
  - skid register holds one overflow entry.
- States: EMPTY (occupancy 0), ONE (occupancy 1), FULL (occupancy 2). in_ready = (state != FULL). out_valid = (state != EMPTY).
- Transitions when flush=0:
  - EMPTY: accept moves to ONE with main loaded. No accept stays in EMPTY.
  - ONE, accept & pop: stays in ONE, main loaded with the new entry.
  - ONE, accept & !pop: moves to FULL, skid loaded.
  - ONE, !accept & pop: moves to EMPTY.
  - ONE, neither: stays in ONE.
  - FULL: in_ready=0, so no accept is possible. pop moves to ONE with main loaded from skid. No pop stays in FULL.
- Stored value on accept: NOP_VALUE if nop_inject=1, else in_data. An injected NOP is a valid entry, counts in occupancy and must be popped like any other entry.
- flush=1 overrides every other event:
  - next state is EMPTY and any accept in that cycle is discarded.
  - a pop in that cycle still counts as consumed by downstream.
  - out_data keeps its previous value.
  - stall_cnt is unaffected.
- Data order is strict FIFO: skid contents are never overtaken by a new accept.
- stall_cnt increments by 1 on each edge where out_valid=1 and out_ready=0. It holds at 2^CNT_W-1 and never wraps. Only Clr clears it.
- When out_valid=0, out_data holds its last value. Downstream must qualify it with out_valid.

## Timing
- Reset: while Clr=1, regardless of Clk:
  - state EMPTY, out_valid=0, in_ready=1, occupancy=0
  - out_data=NOP_VALUE, skid=NOP_VALUE, stall_cnt=0
- The first accept can occur at the first rising edge after Clr deasserts.
- Reset asserted mid-transfer discards all held entries immediately and asynchronously.
- Latency: an entry accepted at edge N is on out_data with out_valid=1 after edge N.
- Throughput: 1 entry/cycle sustained while out_ready=1.
- in_ready drops to 0 after the edge that fills skid. It returns to 1 after the edge that pops from FULL, so one cycle of upstream stall per downstream stall episode.
- All outputs are registered. There is no combinational path from in_valid, in_data, out_ready, flush or nop_inject to any output.
- Simultaneous events:
  - flush with accept and pop: EMPTY next cycle.
  - nop_inject without accept: ignored.
  - pop from FULL: in_ready=1 only from the next cycle.

## Test plan
- Reset and streaming:
  - Stimulus: Clr pulse, then in_valid=1 with in_data = 0x11, 0x22, 0x33 on consecutive cycles, out_ready=1.
  - Response: out_data = 0x11, 0x22, 0x33 one cycle after each accept; occupancy=1 throughout; stall_cnt=0; in_ready=1 always.
- Skid fill:
  - Stimulus: out_ready=0 while 0xA1 and 0xA2 are accepted.
  - Response: occupancy 1 then 2; in_ready=0; a third payload 0xA3 is held upstream.
  - Then set out_ready=1. Response: out_data 0xA1, 0xA2, 0xA3 in order; stall_cnt equals the number of blocked cycles.
- NOP injection:
  - Stimulus: accept 0xDEADBEEF with nop_inject=1.
  - Response: out_data=NOP_VALUE with out_valid=1; the next accept with nop_inject=0 passes its data unchanged.
- Flush:
  - Stimulus: in FULL with 0xB1/0xB2, assert flush together with in_valid=1, in_data=0xB3.
  - Response: next cycle occupancy=0, out_valid=0, in_ready=1, out_data still 0xB1; 0xB3 is lost.
- Counter saturation:
  - Stimulus: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles.
  - Response: stall_cnt reaches 15 and holds; a Clr pulse clears it to 0.
- Async reset mid-operation:
  - Stimulus: assert Clr between clock edges while FULL.
  - Response: out_valid=0, out_data=NOP_VALUE, in_ready=1 immediately, before the next edge.
